// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, flag index and incrementer constants
package cpu_pkg;
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int unsigned INCR_STEP = 4;
endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational data-processing ALU with NZCV generation
module alu_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       opcode,
    input  logic             setflags,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags_out,
    output logic             writeback
);
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic             is_arith;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH:0]   sum;
    logic             ovf;

    // Every arithmetic opcode reduces to x + y + cin; subtraction inverts the subtrahend.
    always_comb begin
        add_x     = '0;
        add_y     = '0;
        add_cin   = 1'b0;
        is_arith  = 1'b0;
        logic_res = '0;
        case (opcode)
            OP_AND, OP_TST: logic_res = a_in & b_in;
            OP_EOR, OP_TEQ: logic_res = a_in ^ b_in;
            OP_SUB, OP_CMP: begin add_x = a_in; add_y = ~b_in; add_cin = 1'b1;            is_arith = 1'b1; end
            OP_RSB:         begin add_x = b_in; add_y = ~a_in; add_cin = 1'b1;            is_arith = 1'b1; end
            OP_ADD, OP_CMN: begin add_x = a_in; add_y = b_in;  add_cin = 1'b0;            is_arith = 1'b1; end
            OP_ADC:         begin add_x = a_in; add_y = b_in;  add_cin = flags_in[FLAG_C]; is_arith = 1'b1; end
            OP_SBC:         begin add_x = a_in; add_y = ~b_in; add_cin = flags_in[FLAG_C]; is_arith = 1'b1; end
            OP_RSC:         begin add_x = b_in; add_y = ~a_in; add_cin = flags_in[FLAG_C]; is_arith = 1'b1; end
            OP_ORR:         logic_res = a_in | b_in;
            OP_MOV:         logic_res = b_in;
            OP_BIC:         logic_res = a_in & ~b_in;
            OP_MVN:         logic_res = ~b_in;
        endcase
    end

    assign sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign alu_out = is_arith ? sum[WIDTH-1:0] : logic_res;
    assign ovf     = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (alu_out[WIDTH-1] != add_x[WIDTH-1]);

    always_comb begin
        flags_out = flags_in;
        if (setflags) begin
            flags_out[FLAG_N] = alu_out[WIDTH-1];
            flags_out[FLAG_Z] = (alu_out == '0);
            if (is_arith) begin
                flags_out[FLAG_C] = sum[WIDTH];
                flags_out[FLAG_V] = ovf;
            end
        end
    end

    // TST/TEQ/CMP/CMN occupy 8..B and only update flags.
    assign writeback = (opcode[3:2] != 2'b10);
endmodule

// File: rtl/addr_alu_unit.sv
// rtl/addr_alu_unit.sv - execute slice: ALU, address register and incrementer
module addr_alu_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int unsigned      INCR_STEP  = cpu_pkg::INCR_STEP,
    parameter logic [WIDTH-1:0] ADDR_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             setflags,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       flags_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             addr_write,
    input  logic             addr_sel_alu,
    input  logic             pc_change,
    input  logic             incr_en,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags_out,
    output logic             writeback,
    output logic [WIDTH-1:0] addr_out,
    output logic [WIDTH-1:0] incr_out
);
    logic [WIDTH-1:0] addr_d;
    logic [WIDTH-1:0] addr_q;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .opcode    (opcode),
        .setflags  (setflags),
        .a_in      (a_in),
        .b_in      (b_in),
        .flags_in  (flags_in),
        .alu_out   (alu_out),
        .flags_out (flags_out),
        .writeback (writeback)
    );

    assign addr_out = addr_q;
    assign incr_out = incr_en ? addr_q + WIDTH'(INCR_STEP) : addr_q;

    // A PC redirect outranks an ALU-computed address; otherwise fall through to sequential fetch.
    always_comb begin
        addr_d = addr_q;
        if (addr_write) begin
            if (pc_change)         addr_d = pc_in;
            else if (addr_sel_alu) addr_d = alu_out;
            else                   addr_d = incr_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) addr_q <= ADDR_RESET;
        else       addr_q <= addr_d;
    end
endmodule

// File: tb/tb_addr_alu_unit.sv
// tb/tb_addr_alu_unit.sv - scoreboard bench for addr_alu_unit
module tb_addr_alu_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = '0;
    logic        setflags = 1'b0;
    logic [31:0] a_in = '0, b_in = '0, pc_in = '0;
    logic [3:0]  flags_in = '0;
    logic        addr_write = 1'b0, addr_sel_alu = 1'b0, pc_change = 1'b0, incr_en = 1'b0;
    logic [31:0] alu_out, addr_out, incr_out;
    logic [3:0]  flags_out;
    logic        writeback;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic        wb;
        logic [31:0] addr;
        logic [31:0] incr;
        bit          addr_known;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_addr = '0;
    bit          model_known = 1'b0;

    addr_alu_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .setflags(setflags),
        .a_in(a_in), .b_in(b_in), .flags_in(flags_in), .pc_in(pc_in),
        .addr_write(addr_write), .addr_sel_alu(addr_sel_alu), .pc_change(pc_change),
        .incr_en(incr_en), .alu_out(alu_out), .flags_out(flags_out),
        .writeback(writeback), .addr_out(addr_out), .incr_out(incr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: plain unsigned/signed integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [3:0] op, input logic sf, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] fl);
        exp_t        e;
        logic [31:0] x, y;
        longint      k, ures, sres;
        bit          arith, sub, c, v;
        arith = 1'b1; sub = 1'b0; k = 0; x = a; y = b;
        e.res = '0;
        case (op)
            4'h0, 4'h8: begin arith = 0; e.res = a & b; end
            4'h1, 4'h9: begin arith = 0; e.res = a ^ b; end
            4'h2, 4'hA: sub = 1;
            4'h3:       begin sub = 1; x = b; y = a; end
            4'h4, 4'hB: ;
            4'h5:       k = fl[1];
            4'h6:       begin sub = 1; k = !fl[1]; end
            4'h7:       begin sub = 1; x = b; y = a; k = !fl[1]; end
            4'hC:       begin arith = 0; e.res = a | b; end
            4'hD:       begin arith = 0; e.res = b; end
            4'hE:       begin arith = 0; e.res = a & ~b; end
            default:    begin arith = 0; e.res = ~b; end
        endcase
        c = fl[1]; v = fl[0];
        if (arith) begin
            if (sub) begin
                ures = longint'(x) - longint'(y) - k;
                sres = longint'($signed(x)) - longint'($signed(y)) - k;
                c = (ures >= 0);
            end else begin
                ures = longint'(x) + longint'(y) + k;
                sres = longint'($signed(x)) + longint'($signed(y)) + k;
                c = (ures > 64'sh0FFFF_FFFF);
            end
            e.res = ures[31:0];
            v = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
        end
        e.flags = sf ? {e.res[31], e.res == 0, c, v} : fl;
        e.wb = !(op >= 4'h8 && op <= 4'hB);
        return e;
    endfunction

    task automatic apply(input bit rst, input logic [3:0] op, input bit sf, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] fl, input logic [31:0] pc,
                         input bit aw, input bit asel, input bit pcc, input bit ie);
        exp_t e;
        @(posedge clk); #1;
        reset = rst; opcode = op; setflags = sf; a_in = a; b_in = b; flags_in = fl;
        pc_in = pc; addr_write = aw; addr_sel_alu = asel; pc_change = pcc; incr_en = ie;
        e = model(op, sf, a, b, fl);
        e.addr = model_addr;
        e.incr = ie ? model_addr + 32'd4 : model_addr;
        e.addr_known = model_known;
        sb.push_back(e);
        if (rst)       begin model_addr = '0; model_known = 1'b1; end
        else if (!aw)  model_addr = model_addr;
        else if (pcc)  model_addr = pc;
        else if (asel) model_addr = e.res;
        else           model_addr = e.incr;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("alu_out", alu_out, e.res);
            chk("flags_out", {28'd0, flags_out}, {28'd0, e.flags});
            chk("writeback", {31'd0, writeback}, {31'd0, e.wb});
            if (e.addr_known) begin
                chk("addr_out", addr_out, e.addr);
                chk("incr_out", incr_out, e.incr);
            end
        end
    end

    initial begin
        apply(1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        // Sequential fetch after reset
        for (int i = 0; i < 4; i++) begin
            apply(0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1);
            #1 chk("seq_addr", addr_out, 32'(i * 4));
            chk("seq_incr", incr_out, 32'(i * 4 + 4));
        end
        apply(0, 4'h4, 1, 32'h7FFF_FFFF, 1, 4'h0, 0, 0, 0, 0, 1);
        #1 chk("add_res", alu_out, 32'h8000_0000);
        chk("add_nzcv", {28'd0, flags_out}, 32'h9);
        chk("add_wb", {31'd0, writeback}, 32'd1);
        apply(0, 4'hA, 1, 5, 5, 4'h0, 0, 0, 0, 0, 1);
        #1 chk("cmp_eq_res", alu_out, 32'h0);
        chk("cmp_eq_nzcv", {28'd0, flags_out}, 32'h6);
        chk("cmp_wb", {31'd0, writeback}, 32'd0);
        apply(0, 4'hA, 1, 3, 5, 4'h0, 0, 0, 0, 0, 1);
        #1 chk("cmp_lt_res", alu_out, 32'hFFFF_FFFE);
        chk("cmp_lt_nzcv", {28'd0, flags_out}, 32'h8);
        apply(0, 4'h5, 1, 32'hFFFF_FFFF, 0, 4'h2, 0, 0, 0, 0, 1);
        #1 chk("adc_res", alu_out, 32'h0);
        chk("adc_zc", {30'd0, flags_out[2:1]}, 32'h3);
        apply(0, 4'hD, 0, 32'h1234, 32'hCAFE_F00D, 4'h5, 0, 0, 0, 0, 1);
        #1 chk("mov_res", alu_out, 32'hCAFE_F00D);
        chk("mov_flags", {28'd0, flags_out}, 32'h5);
        // Redirect priority: pc_change beats addr_sel_alu, then hold
        apply(0, 4'hD, 0, 0, 32'h200, 4'h0, 32'h100, 1, 1, 1, 1);
        apply(0, 4'hD, 0, 0, 32'h200, 4'h0, 32'h100, 1, 1, 0, 1);
        #1 chk("pc_redirect", addr_out, 32'h100);
        apply(0, 4'hD, 0, 0, 32'h300, 4'h0, 32'h100, 0, 1, 1, 1);
        #1 chk("alu_redirect", addr_out, 32'h200);
        apply(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        #1 chk("hold", addr_out, 32'h200);
        // Wrap at top of address space, then reset mid-sequence
        apply(0, 4'h0, 0, 0, 0, 4'h0, 32'hFFFF_FFFC, 1, 0, 1, 1);
        apply(0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1);
        #1 chk("wrap_incr", incr_out, 32'h0);
        apply(1, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1);
        #1 chk("wrap_addr", addr_out, 32'h0);
        apply(0, 4'h0, 0, 0, 0, 4'h0, 32'h500, 1, 0, 1, 1);
        #1 chk("mid_reset", addr_out, 32'h0);
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(31) == 0, 4'($urandom), 1'($urandom), $urandom, $urandom,
                  4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(3) != 0,
                  1'($urandom), $urandom_range(7) == 0, $urandom_range(7) != 0);
        end
        @(posedge clk);
        @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/addr_alu_unit.md
Name: addr_alu_unit

Overview:
- Execute-stage datapath slice of the ARM-style multi-cycle CPU. Contains the 32-bit ALU (16 ARM data-processing opcodes, NZCV flags), the address register that drives the memory address bus, and the +4 address incrementer.
- The ALU result and the PC bus can redirect the address register; otherwise it advances sequentially through the incrementer.

Parameters:
- WIDTH, 32, datapath width; all buses and arithmetic use it.
- INCR_STEP, 4, constant added by the incrementer.
- ADDR_RESET, 0, address register value after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  4  ALU opcode
- setflags  in  1  1 = flags_out carries computed NZCV
- a_in  in  32  ALU operand A (Rn)
- b_in  in  32  ALU operand B (barrel-shifter output)
- flags_in  in  4  NZCV from the shifter; bit3=N, bit2=Z, bit1=C, bit0=V
- pc_in  in  32  PC bus from the register bank
- addr_write  in  1  address register load enable
- addr_sel_alu  in  1  load the ALU result into the address register
- pc_change  in  1  load pc_in into the address register
- incr_en  in  1  incrementer enable
- alu_out  out  32  ALU result, combinational
- flags_out  out  4  NZCV, combinational
- writeback  out  1  1 = result is to be written to Rd
- addr_out  out  32  address register value, drives the memory address bus
- incr_out  out  32  incrementer output

Behaviour:
- ALU is purely combinational, with zero latency.
- Opcodes:
  - 0 AND a&b; 1 EOR a^b; 2 SUB a-b; 3 RSB b-a
  - 4 ADD a+b; 5 ADC a+b+C; 6 SBC a-b-!C; 7 RSC b-a-!C
  - 8 TST a&b; 9 TEQ a^b; A CMP a-b; B CMN a+b
  - C ORR a|b; D MOV b; E BIC a&~b; F MVN ~b
- C in ADC/SBC/RSC means flags_in[1].
- writeback = 0 for opcodes 8-B and 1 for all others. alu_out is still driven with the computed value for 8-B.
- Flags when setflags=1:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry out of the 33-bit sum. Subtraction is computed as x + ~y + 1 (or + C for the SBC/RSC forms), so C=1 means no borrow.
  - Arithmetic ops: V = signed overflow, i.e. operands of the effective addition share a sign that differs from the result sign.
  - Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = flags_in[1], V = flags_in[0].
- When setflags=0: flags_out = flags_in unchanged.
- All arithmetic wraps modulo 2^32.
- Incrementer is combinational: incr_out = addr_out + INCR_STEP when incr_en=1, else addr_out. It wraps, so 0xFFFFFFFC -> 0x00000000.
- Address register updates on the rising clk edge. Priority: reset > !addr_write (hold) > pc_change (pc_in) > addr_sel_alu (alu_out) > incr_out.
- With addr_write=1 and no select active, the register advances by the incrementer every cycle.
- When reset is high at an edge, addr_out = ADDR_RESET, overriding every other input, including a reset asserted in the middle of a sequence. Outputs are valid in the cycle after that edge.
- Immediately after reset: addr_out = 0 and incr_out = 4 (when incr_en=1).
- All other outputs are combinational functions of the current inputs and addr_out. There is no internal state besides the address register.
- X-free: every opcode value is decoded, so there is no default-X branch.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_AND..OP_MVN;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - INCR_STEP.
- One sub-module, alu_core: the combinational ALU with its flag logic. The address register and incrementer sit inline in the top level.

Test Plan:
- Reset, then addr_write=1, incr_en=1, no selects for 3 cycles -> addr_out 0,4,8,12; incr_out is always addr_out+4.
- ADD (4), a=0x7FFFFFFF, b=1, setflags=1 -> alu_out=0x80000000, NZCV=1001, writeback=1.
- CMP (A), a=5, b=5, setflags=1 -> alu_out=0, NZCV=0110, writeback=0. Then a=3, b=5 -> alu_out=0xFFFFFFFE, NZCV=1000.
- ADC (5), a=0xFFFFFFFF, b=0, flags_in C=1 -> alu_out=0, Z=1, C=1. MOV (D) with setflags=0 and flags_in=0101 -> alu_out=b, flags_out=0101.
- pc_change=1, addr_sel_alu=1, pc_in=0x100, alu_out=0x200 -> addr_out=0x100 next cycle. pc_change=0 -> addr_out=0x200. addr_write=0 -> holds the value.
- Address register at 0xFFFFFFFC, increment -> addr_out=0. Reset asserted mid-sequence -> addr_out=0 on the next edge.
